// File: rtl/operand_crossbar.sv
// Operand crossbar: routes PHV containers to per-container ALU operands as selected by the
// action word, behind a two-entry skid buffer with a registered ready.
module operand_crossbar #(
    parameter int unsigned NUM_CONT = 64,
    parameter int unsigned CONT_W   = 32,
    parameter int unsigned ACT_LEN  = 64,
    parameter int unsigned META_W   = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CONT*CONT_W+META_W-1:0] phv_in,
    input  logic                            phv_in_valid,
    input  logic [ACT_LEN*(NUM_CONT+1)-1:0] action_in,
    input  logic                            action_in_valid,
    output logic                            ready_out,
    output logic                            alu_in_valid,
    output logic [NUM_CONT*CONT_W-1:0]      alu_in_1,
    output logic [NUM_CONT*CONT_W-1:0]      alu_in_2,
    output logic [NUM_CONT*CONT_W-1:0]      alu_in_3,
    output logic [META_W-1:0]               phv_remain_data,
    output logic [ACT_LEN*(NUM_CONT+1)-1:0] action_out,
    input  logic                            ready_in,
    output logic [15:0]                     idx_err_cnt
);

    localparam int unsigned PHV_LEN = NUM_CONT*CONT_W+META_W;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned VEC_W   = NUM_CONT*CONT_W;
    localparam int unsigned ACT_W   = ACT_LEN*(NUM_CONT+1);
    localparam int unsigned BEAT_W  = 3*VEC_W+META_W+ACT_W;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e              state_q, state_d;
    logic                ready_q;
    logic [BEAT_W-1:0]   out_q, skid_q;
    logic [15:0]         cnt_q, cnt_d;
    logic                load_out_in, load_out_skid, load_skid;
    logic                accept, consume;

    // Index table padded to the full index range; out-of-range slots alias container 0.
    logic [CONT_W-1:0]   cont_ext [2**IDX_W];
    logic [VEC_W-1:0]    op_a, op_b, op_c;
    logic [15:0]         err_inc;
    logic [BEAT_W-1:0]   beat_in;
    logic [16:0]         cnt_sum;

    always_comb begin
        for (int i = 0; i < 2**IDX_W; i++) begin
            cont_ext[i] = phv_in[META_W +: CONT_W];
        end
        for (int k = 0; k < NUM_CONT; k++) begin
            cont_ext[k] = phv_in[META_W + k*CONT_W +: CONT_W];
        end
        op_a    = '0;
        op_b    = '0;
        op_c    = '0;
        err_inc = '0;
        for (int k = 0; k < NUM_CONT; k++) begin
            logic [ACT_LEN-1:0] sub;
            logic [7:0]         opc;
            logic [IDX_W-1:0]   ia, ib;
            logic [CONT_W-1:0]  a, b;
            sub = action_in[(k+1)*ACT_LEN +: ACT_LEN];
            opc = sub[63:56];
            ia  = sub[55:50];
            ib  = sub[49:44];
            a   = cont_ext[k];
            b   = '0;
            if (action_in_valid) begin
                case (opc)
                    8'h01, 8'h02, 8'h07, 8'h08, 8'h0B: begin
                        a = cont_ext[ia];
                        b = cont_ext[ib];
                        if (32'(ia) >= NUM_CONT) err_inc = err_inc + 16'd1;
                        if (32'(ib) >= NUM_CONT) err_inc = err_inc + 16'd1;
                    end
                    8'h09, 8'h0A: begin
                        a = cont_ext[ia];
                        b = sub[CONT_W-1:0];
                        if (32'(ia) >= NUM_CONT) err_inc = err_inc + 16'd1;
                    end
                    8'h0E: begin
                        a = '0;
                        b = sub[CONT_W-1:0];
                    end
                    default: ;
                endcase
            end
            op_a[k*CONT_W +: CONT_W] = a;
            op_b[k*CONT_W +: CONT_W] = b;
            op_c[k*CONT_W +: CONT_W] = cont_ext[k];
        end
    end

    assign beat_in = {op_a, op_b, op_c, phv_in[META_W-1:0], action_in};
    assign accept  = phv_in_valid && ready_q;
    assign consume = (state_q != StEmpty) && ready_in;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    load_out_in = 1'b1;
                end
            end
            StOne: begin
                if (accept && consume) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (consume) begin
                    state_d       = StOne;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    assign cnt_sum = {1'b0, cnt_q} + {1'b0, err_inc};
    assign cnt_d   = !accept ? cnt_q : (cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != StFull);
            cnt_q   <= cnt_d;
            if (load_out_in) begin
                out_q <= beat_in;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) skid_q <= beat_in;
        end
    end

    assign ready_out    = ready_q;
    assign alu_in_valid = (state_q != StEmpty);
    assign idx_err_cnt  = cnt_q;
    assign {alu_in_1, alu_in_2, alu_in_3, phv_remain_data, action_out} = out_q;

    logic unused_len;
    assign unused_len = ^PHV_LEN;

endmodule

// File: tb/tb_operand_crossbar.sv
// Directed-vector bench for operand_crossbar with 48 containers, so out-of-range indices exist.
module tb_operand_crossbar;

    localparam int NC = 48;
    localparam int CW = 32;
    localparam int AL = 64;
    localparam int MW = 32;

    logic                   clk;
    logic                   rst_n;
    logic [NC*CW+MW-1:0]    phv_in;
    logic                   phv_in_valid;
    logic [AL*(NC+1)-1:0]   action_in;
    logic                   action_in_valid;
    logic                   ready_out;
    logic                   alu_in_valid;
    logic [NC*CW-1:0]       alu_in_1, alu_in_2, alu_in_3;
    logic [MW-1:0]          phv_remain_data;
    logic [AL*(NC+1)-1:0]   action_out;
    logic                   ready_in;
    logic [15:0]            idx_err_cnt;

    int nvec = 0;
    int nerr = 0;

    operand_crossbar #(
        .NUM_CONT (NC),
        .CONT_W   (CW),
        .ACT_LEN  (AL),
        .META_W   (MW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .action_in       (action_in),
        .action_in_valid (action_in_valid),
        .ready_out       (ready_out),
        .alu_in_valid    (alu_in_valid),
        .alu_in_1        (alu_in_1),
        .alu_in_2        (alu_in_2),
        .alu_in_3        (alu_in_3),
        .phv_remain_data (phv_remain_data),
        .action_out      (action_out),
        .ready_in        (ready_in),
        .idx_err_cnt     (idx_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sa(input logic [7:0] op, input logic [5:0] ia,
                                       input logic [5:0] ib, input logic [31:0] imm);
        return {op, ia, ib, 12'h000, imm};
    endfunction

    task automatic set_phv(input logic [31:0] base, input logic [31:0] meta);
        for (int k = 0; k < NC; k++) phv_in[MW + k*CW +: CW] = base + 32'(k);
        phv_in[MW-1:0] = meta;
    endtask

    function automatic logic [31:0] ga(input int k);
        return alu_in_1[k*CW +: CW];
    endfunction
    function automatic logic [31:0] gb(input int k);
        return alu_in_2[k*CW +: CW];
    endfunction
    function automatic logic [31:0] gc(input int k);
        return alu_in_3[k*CW +: CW];
    endfunction

    initial begin
        rst_n = 1'b1;
        phv_in = '0;
        phv_in_valid = 1'b0;
        action_in = '0;
        action_in_valid = 1'b0;
        ready_in = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", alu_in_valid, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_cnt", idx_err_cnt, 0);
        chk("rst_a0", ga(0), 0);
        @(negedge clk) rst_n = 1'b1;

        // Two-register select on container 3
        set_phv(0, 32'hA5A5_0001);
        action_in = '0;
        action_in[4*AL +: AL] = sa(8'h01, 6'd5, 6'd9, 0);
        action_in_valid = 1'b1;
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t1_valid", alu_in_valid, 1);
        chk("t1_a3", ga(3), 5);
        chk("t1_b3", gb(3), 9);
        chk("t1_c3", gc(3), 3);
        chk("t1_a10", ga(10), 10);
        chk("t1_b10", gb(10), 0);
        chk("t1_meta", phv_remain_data, 32'hA5A5_0001);
        chk("t1_act4", action_out[4*AL +: AL], sa(8'h01, 6'd5, 6'd9, 0));

        // Immediate forms and unknown opcode
        action_in = '0;
        action_in[1*AL +: AL] = sa(8'h0E, 6'd7, 6'd7, 32'hDEADBEEF);
        action_in[3*AL +: AL] = sa(8'h09, 6'd2, 6'd0, 32'd7);
        action_in[6*AL +: AL] = sa(8'h05, 6'd1, 6'd1, 32'd99);
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t2_a0", ga(0), 0);
        chk("t2_b0", gb(0), 32'hDEADBEEF);
        chk("t2_a2", ga(2), 2);
        chk("t2_b2", gb(2), 7);
        chk("t2_a5", ga(5), 5);
        chk("t2_b5", gb(5), 0);

        // action_in_valid low forces pass-through but action_out is still forwarded
        action_in = '0;
        action_in[4*AL +: AL] = sa(8'h01, 6'd5, 6'd9, 0);
        action_in_valid = 1'b0;
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t3_a3", ga(3), 3);
        chk("t3_b3", gb(3), 0);
        chk("t3_act4", action_out[4*AL +: AL], sa(8'h01, 6'd5, 6'd9, 0));
        chk("t3_cnt", idx_err_cnt, 0);

        // Out-of-range indices: only indices that the opcode uses are counted
        set_phv(32'h100, 32'hA5A5_0002);
        action_in = '0;
        action_in[1*AL +: AL] = sa(8'h01, 6'd50, 6'd3, 0);
        action_in[2*AL +: AL] = sa(8'h09, 6'd63, 6'd60, 32'h55);
        action_in[3*AL +: AL] = sa(8'h05, 6'd50, 6'd50, 0);
        action_in_valid = 1'b1;
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t4_a0", ga(0), 32'h100);
        chk("t4_b0", gb(0), 32'h103);
        chk("t4_a1", ga(1), 32'h100);
        chk("t4_b1", gb(1), 32'h55);
        chk("t4_a2", ga(2), 32'h102);
        chk("t4_cnt", idx_err_cnt, 2);

        // Skid: three beats against a stalled sink
        @(negedge clk);
        chk("t5_empty", alu_in_valid, 0);
        ready_in = 1'b0;
        action_in = '0;
        action_in_valid = 1'b0;
        set_phv(32'h0000, 32'hBEE0_0000);
        phv_in_valid = 1'b1;
        @(negedge clk);
        chk("t5_p0_valid", alu_in_valid, 1);
        chk("t5_rdy1", ready_out, 1);
        set_phv(32'h1000, 32'hBEE0_0001);
        @(negedge clk);
        chk("t5_rdy_full", ready_out, 0);
        chk("t5_hold_p0", phv_remain_data, 32'hBEE0_0000);
        set_phv(32'h2000, 32'hBEE0_0002);
        repeat (3) @(negedge clk);
        chk("t5_still_p0", phv_remain_data, 32'hBEE0_0000);
        chk("t5_still_a7", ga(7), 7);
        chk("t5_still_full", ready_out, 0);
        ready_in = 1'b1;
        @(negedge clk);
        chk("t5_p1_meta", phv_remain_data, 32'hBEE0_0001);
        chk("t5_p1_a7", ga(7), 32'h1007);
        chk("t5_rdy_one", ready_out, 1);
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t5_p2_meta", phv_remain_data, 32'hBEE0_0002);
        chk("t5_p2_a7", ga(7), 32'h2007);
        chk("t5_p2_valid", alu_in_valid, 1);
        @(negedge clk);
        chk("t5_drained", alu_in_valid, 0);

        // Reset while FULL discards both entries
        ready_in = 1'b0;
        set_phv(0, 32'hC0DE_0000);
        phv_in_valid = 1'b1;
        @(negedge clk);
        set_phv(0, 32'hC0DE_0001);
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t6_full", ready_out, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", alu_in_valid, 0);
        chk("t6_rst_ready", ready_out, 1);
        chk("t6_rst_a0", ga(0), 0);
        chk("t6_rst_cnt", idx_err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_in = 1'b1;
        set_phv(0, 32'hC0DE_0003);
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t6_new_valid", alu_in_valid, 1);
        chk("t6_new_meta", phv_remain_data, 32'hC0DE_0003);
        @(negedge clk);
        chk("t6_no_stale", alu_in_valid, 0);

        // Saturation: 96 bad indices per beat, one beat accepted per cycle
        set_phv(32'h20, 32'h5A7_0000);
        action_in = '0;
        for (int k = 0; k < NC; k++) action_in[(k+1)*AL +: AL] = sa(8'h01, 6'd50, 6'd60, 0);
        action_in_valid = 1'b1;
        phv_in_valid = 1'b1;
        @(negedge clk);
        chk("t7_cnt1", idx_err_cnt, 96);
        chk("t7_a0", ga(0), 32'h20);
        chk("t7_b47", gb(47), 32'h20);
        repeat (600) @(negedge clk);
        chk("t7_cnt601", idx_err_cnt, 16'hE160);
        repeat (81) @(negedge clk);
        chk("t7_cnt682", idx_err_cnt, 16'hFFC0);
        @(negedge clk);
        chk("t7_sat", idx_err_cnt, 16'hFFFF);
        repeat (5) @(negedge clk);
        phv_in_valid = 1'b0;
        chk("t7_sat_hold", idx_err_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/operand_crossbar.md
OPERAND_CROSSBAR -- requirements
Module: operand_crossbar

Interface
REQ-001 SHALL have parameter NUM_CONT, default 64, number of PHV containers routed to ALUs.
REQ-002 SHALL have parameter CONT_W, default 32, container width in bits.
REQ-003 SHALL have parameter ACT_LEN, default 64, bits per sub-action.
REQ-004 SHALL have parameter META_W, default 256, PHV tail bits passed unmodified.
REQ-005 SHALL have derived localparams:
- PHV_LEN = NUM_CONT*CONT_W+META_W
- IDX_W = 6 (index field width, fixed by action format)
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 phv_in  input  PHV_LEN  container k at [PHV_LEN-1-CONT_W*(NUM_CONT-1-k) -: CONT_W]; meta at [META_W-1:0].
REQ-009 phv_in_valid  input  1  phv_in/action_in valid.
REQ-010 action_in  input  ACT_LEN*(NUM_CONT+1)  sub-action j at [j*ACT_LEN +: ACT_LEN]; sub-action k+1 controls container k.
REQ-011 action_in_valid  input  1  action_in qualifier.
REQ-012 ready_out  output  1  block can accept a beat.
REQ-013 alu_in_valid  output  1  output beat valid.
REQ-014 alu_in_1, alu_in_2, alu_in_3  output  NUM_CONT*CONT_W each  operand A, operand B, original container; container k at [(k+1)*CONT_W-1 -: CONT_W].
REQ-015 phv_remain_data  output  META_W  meta of same beat.
REQ-016 action_out  output  ACT_LEN*(NUM_CONT+1)  action_in of same beat, aligned with operands.
REQ-017 ready_in  input  1  downstream ALUs accept beat.
REQ-018 idx_err_cnt  output  16  count of out-of-range operand indices.

Function
REQ-019 Input beat SHALL be accepted when phv_in_valid && ready_out; output beat consumed when alu_in_valid && ready_in.
REQ-020 Per container k, opcode op = sub-action[k+1][63:56], idxA = [55:50], idxB = [49:44], imm = [CONT_W-1:0] zero-extended/truncated to CONT_W.
REQ-021 Operand selection:
- op 0x01, 0x02, 0x07, 0x08, 0x0B: A=cont[idxA], B=cont[idxB]
- op 0x09, 0x0A: A=cont[idxA], B=imm
- op 0x0E: A=0, B=imm
- other op: A=cont[k], B=0
- always: alu_in_3 = cont[k]
REQ-022 Index >= NUM_CONT SHALL select operand 0; each such used index in an accepted beat increments idx_err_cnt by 1, saturating at 0xFFFF.
REQ-023 Accepted beat with action_in_valid=0 SHALL use default (pass-through) selection for all containers; action_out carries action_in unchanged.
REQ-024 Latency SHALL be exactly 1 cycle from acceptance to alu_in_valid when output stage is empty or draining.
REQ-025 Buffering SHALL be a 2-entry skid: output register (OUT) plus skid register (SKID); states EMPTY, ONE, FULL.
REQ-026 EMPTY: accept -> ONE.
REQ-027 ONE:
- accept & consume -> ONE
- accept & no consume -> FULL, beat into SKID
- consume only -> EMPTY
REQ-028 FULL: consume -> ONE, SKID moves to OUT same edge; no accept possible.
REQ-029 ready_out SHALL be registered, equal to (state != FULL); no beat is ever dropped or duplicated.
REQ-030 Output registers SHALL hold stable while alu_in_valid && !ready_in.
REQ-031 Beat ordering SHALL be strictly FIFO.

Reset
REQ-032 On rst_n low, asynchronously:
- state=EMPTY, alu_in_valid=0, ready_out=1
- alu_in_1/2/3, phv_remain_data, action_out, SKID = 0
- idx_err_cnt=0
REQ-033 Reset mid-stall SHALL discard OUT and SKID contents; first beat after release emerges 1 cycle after acceptance.

Verification
REQ-034 NUM_CONT=64, ready_in=1, cont[k]=k, sub-action[4]=op 0x01 idxA=5 idxB=9 -> next cycle container 3: A=5, B=9, alu_in_3=3; others A=k, B=0.
REQ-035 sub-action[1]=op 0x0E imm=0xDEADBEEF -> container 0: A=0, B=0xDEADBEEF; op 0x09 idxA=2 imm=7 -> A=2, B=7.
REQ-036 ready_in=0, three back-to-back valid beats P0, P1, P2 -> P0 in OUT, P1 in SKID, ready_out=0 after 2nd accept, P2 held off; ready_in=1 -> P0, P1, P2 in order, none lost.
REQ-037 NUM_CONT=48, idxA=50 on op 0x01 -> A=cont[0], idx_err_cnt increments 0->1; counter preloaded near 0xFFFF saturates at 0xFFFF.
REQ-038 Assert rst_n=0 while FULL -> alu_in_valid=0, ready_out=1 immediately; after release a new beat appears 1 cycle after acceptance.
